// File: rtl/rast_pkg.sv
// Shared rasteriser types: depth functions, fragment record and sequencer states.
// Used by the depth-test sequencer, z_buffer and the fragment generator.
package rast_pkg;

  localparam int Z_SIZE       = 8;
  localparam int COL_SIZE     = 16;
  localparam int X_RES        = 4;
  localparam int Y_RES        = 4;
  localparam int X_PIXEL_SIZE = $clog2(X_RES);
  localparam int Y_PIXEL_SIZE = $clog2(Y_RES);

  typedef enum logic [2:0] {
    GL_NEVER    = 3'b000,
    GL_LESS     = 3'b001,
    GL_EQUAL    = 3'b010,
    GL_LEQUAL   = 3'b011,
    GL_GREATER  = 3'b100,
    GL_NOTEQUAL = 3'b101,
    GL_GEQUAL   = 3'b110,
    GL_ALWAYS   = 3'b111
  } z_func_t;

  typedef struct packed {
    logic [X_PIXEL_SIZE-1:0] x;
    logic [Y_PIXEL_SIZE-1:0] y;
    logic [Z_SIZE-1:0]       z;
    logic [COL_SIZE-1:0]     col;
  } fragment_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_CLR_ISSUE,
    S_CLR_WAIT
  } seq_state_t;

endpackage

// File: rtl/depth_test_sequencer_if.sv
// Bus bundle for the depth-test sequencer: fragment input, clear request, z_buffer link, output stream.
// Signal suffixes are relative to the sequencer; master is the sequencer, slave its environment.
interface depth_test_sequencer_if #(parameter int ADDR_SIZE = 32);
  import rast_pkg::*;

  logic                    frag_valid_i;
  logic                    frag_ready_o;
  logic [X_PIXEL_SIZE-1:0] frag_x_i;
  logic [Y_PIXEL_SIZE-1:0] frag_y_i;
  logic [Z_SIZE-1:0]       frag_z_i;
  logic [COL_SIZE-1:0]     frag_col_i;
  logic                    clear_valid_i;
  logic                    clear_ready_o;
  z_func_t                 z_func_i;
  logic [ADDR_SIZE-1:0]    zbuf_base_i;

  logic                    zb_start_o;
  logic                    zb_flush_o;
  logic [X_PIXEL_SIZE-1:0] zb_x_o;
  logic [Y_PIXEL_SIZE-1:0] zb_y_o;
  logic [Z_SIZE-1:0]       zb_z_o;
  z_func_t                 zb_func_o;
  logic [ADDR_SIZE-1:0]    zb_base_o;
  logic                    zb_done_i;
  logic                    zb_pass_i;

  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [X_PIXEL_SIZE-1:0] out_x_o;
  logic [Y_PIXEL_SIZE-1:0] out_y_o;
  logic [Z_SIZE-1:0]       out_z_o;
  logic [COL_SIZE-1:0]     out_col_o;

  modport master (
    input  frag_valid_i, frag_x_i, frag_y_i, frag_z_i, frag_col_i,
           clear_valid_i, z_func_i, zbuf_base_i, zb_done_i, zb_pass_i, out_ready_i,
    output frag_ready_o, clear_ready_o, zb_start_o, zb_flush_o, zb_x_o, zb_y_o, zb_z_o,
           zb_func_o, zb_base_o, out_valid_o, out_x_o, out_y_o, out_z_o, out_col_o
  );

  modport slave (
    output frag_valid_i, frag_x_i, frag_y_i, frag_z_i, frag_col_i,
           clear_valid_i, z_func_i, zbuf_base_i, zb_done_i, zb_pass_i, out_ready_i,
    input  frag_ready_o, clear_ready_o, zb_start_o, zb_flush_o, zb_x_o, zb_y_o, zb_z_o,
           zb_func_o, zb_base_o, out_valid_o, out_x_o, out_y_o, out_z_o, out_col_o
  );

endinterface

// File: rtl/frag_fifo.sv
// Synchronous fragment queue with valid/ready on both sides; DEPTH must be a power of two.
// in_ready depends only on fill level, so push and pop may coincide without a combinational path.
module frag_fifo import rast_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      in_valid,
  output logic      in_ready,
  input  fragment_t in_data,
  output logic      out_valid,
  input  logic      out_ready,
  output fragment_t out_data
);

  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W:0] ptr_t;

  fragment_t mem [DEPTH];
  ptr_t      wr_ptr, rd_ptr;
  logic      push, pop, full, empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr[PTR_W-1:0]];

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= in_data;
  end

endmodule

// File: rtl/depth_test_sequencer.sv
// Queues fragments, issues each to z_buffer as a single start pulse, forwards passing ones
// downstream and sequences depth-buffer clears in stream order, keeping pass/fail counts.
module depth_test_sequencer import rast_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_SIZE   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  depth_test_sequencer_if.master bus,
  output logic [CNT_SIZE-1:0]   pass_cnt_o,
  output logic [CNT_SIZE-1:0]   fail_cnt_o,
  output logic                  busy_o
);

  seq_state_t state, state_nxt;
  fragment_t  fifo_in, fifo_out, frag_q;
  logic       fifo_in_ready, fifo_out_valid;
  logic       pop, clearing, clear_go;

  assign clearing          = (state == S_CLR_ISSUE) || (state == S_CLR_WAIT);
  assign bus.frag_ready_o  = fifo_in_ready && !clearing;
  assign fifo_in           = '{x: bus.frag_x_i, y: bus.frag_y_i, z: bus.frag_z_i, col: bus.frag_col_i};

  frag_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (bus.frag_valid_i && !clearing),
    .in_ready  (fifo_in_ready),
    .in_data   (fifo_in),
    .out_valid (fifo_out_valid),
    .out_ready (pop),
    .out_data  (fifo_out)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (clear_go) state_nxt = S_CLR_ISSUE;
                   else if (fifo_out_valid) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT;
      S_WAIT:      if (bus.zb_done_i) state_nxt = bus.zb_pass_i ? S_EMIT : S_IDLE;
      S_EMIT:      if (bus.out_ready_i) state_nxt = S_IDLE;
      S_CLR_ISSUE: state_nxt = S_CLR_WAIT;
      S_CLR_WAIT:  if (bus.zb_done_i) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    bus.clear_ready_o = 1'b0;
    clear_go          = 1'b0;
    pop               = 1'b0;
    busy_o            = 1'b1;
    bus.zb_start_o    = (state == S_ISSUE) || (state == S_CLR_ISSUE);
    bus.zb_flush_o    = clearing;
    bus.out_valid_o   = (state == S_EMIT);
    if (state == S_IDLE) begin
      bus.clear_ready_o = !fifo_out_valid;
      clear_go          = bus.clear_valid_i && !fifo_out_valid;
      pop               = fifo_out_valid && !clear_go;
      busy_o            = fifo_out_valid;
    end
  end

  // Function and base are captured on the pop edge so they are already stable when start rises.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frag_q        <= '0;
      bus.zb_func_o <= GL_NEVER;
      bus.zb_base_o <= '0;
      pass_cnt_o    <= '0;
      fail_cnt_o    <= '0;
    end else begin
      if (pop) begin
        frag_q        <= fifo_out;
        bus.zb_func_o <= bus.z_func_i;
        bus.zb_base_o <= bus.zbuf_base_i;
      end
      if (state == S_WAIT && bus.zb_done_i) begin
        if (bus.zb_pass_i) pass_cnt_o <= pass_cnt_o + CNT_SIZE'(1);
        else               fail_cnt_o <= fail_cnt_o + CNT_SIZE'(1);
      end
    end
  end

  assign bus.zb_x_o    = frag_q.x;
  assign bus.zb_y_o    = frag_q.y;
  assign bus.zb_z_o    = frag_q.z;
  assign bus.out_x_o   = frag_q.x;
  assign bus.out_y_o   = frag_q.y;
  assign bus.out_z_o   = frag_q.z;
  assign bus.out_col_o = frag_q.col;

endmodule

// File: tb/tb_depth_test_sequencer.sv
// Directed bench for depth_test_sequencer with a behavioural z_buffer (stored depths reset to 255,
// done two cycles after the start edge). Vector table for single fragments plus corner sequences.
module tb_depth_test_sequencer;
  import rast_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pass_cnt, fail_cnt;
  logic        busy;

  always #5 clk = ~clk;

  depth_test_sequencer_if #(.ADDR_SIZE(32)) bus ();

  depth_test_sequencer #(.FIFO_DEPTH(4), .CNT_SIZE(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .pass_cnt_o (pass_cnt),
    .fail_cnt_o (fail_cnt),
    .busy_o     (busy)
  );

  int checks = 0, errors = 0;
  int exp_pass_cnt = 0, exp_fail_cnt = 0;
  int start_cnt = 0, coincide_cnt = 0;

  // ---------------- behavioural z_buffer ----------------
  logic [7:0] zmem [16];
  logic       zb_pend, cap_flush;
  logic [1:0] zb_cnt;
  z_func_t    cap_func;
  logic [7:0] cap_z;
  logic [3:0] cap_idx;

  function automatic logic depth_ok(input z_func_t f, input logic [7:0] z, input logic [7:0] s);
    case (f)
      GL_NEVER:    return 1'b0;
      GL_LESS:     return z <  s;
      GL_EQUAL:    return z == s;
      GL_LEQUAL:   return z <= s;
      GL_GREATER:  return z >  s;
      GL_NOTEQUAL: return z != s;
      GL_GEQUAL:   return z >= s;
      default:     return 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.zb_start_o) start_cnt <= start_cnt + 1;
    if (bus.zb_start_o && bus.zb_done_i) coincide_cnt <= coincide_cnt + 1;
    if (rst) begin
      zb_pend       <= 1'b0;
      zb_cnt        <= '0;
      bus.zb_done_i <= 1'b0;
      bus.zb_pass_i <= 1'b0;
      for (int i = 0; i < 16; i++) zmem[i] <= 8'hFF;
    end else begin
      bus.zb_done_i <= 1'b0;
      bus.zb_pass_i <= 1'b0;
      if (zb_pend) begin
        if (zb_cnt == 0) begin
          bus.zb_done_i <= 1'b1;
          zb_pend       <= 1'b0;
          if (cap_flush) begin
            for (int i = 0; i < 16; i++) zmem[i] <= 8'hFF;
          end else if (depth_ok(cap_func, cap_z, zmem[cap_idx])) begin
            bus.zb_pass_i  <= 1'b1;
            zmem[cap_idx]  <= cap_z;
          end
        end else begin
          zb_cnt <= zb_cnt - 2'd1;
        end
      end else if (bus.zb_start_o) begin
        zb_pend   <= 1'b1;
        zb_cnt    <= 2'd1;
        cap_flush <= bus.zb_flush_o;
        cap_func  <= bus.zb_func_o;
        cap_z     <= bus.zb_z_o;
        cap_idx   <= {bus.zb_y_o, bus.zb_x_o};
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frag(input logic [1:0] x, input logic [1:0] y, input logic [7:0] z,
                            input logic [15:0] col);
    bus.frag_valid_i = 1'b1;
    bus.frag_x_i     = x;
    bus.frag_y_i     = y;
    bus.frag_z_i     = z;
    bus.frag_col_i   = col;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_frag_ready"},  bus.frag_ready_o,  1);
    check({tag, "_clear_ready"}, bus.clear_ready_o, 1);
    check({tag, "_busy"},        busy,              0);
    check({tag, "_start_flush"}, {bus.zb_start_o, bus.zb_flush_o}, 0);
    check({tag, "_out_valid"},   bus.out_valid_o,   0);
    check({tag, "_counters"},    {pass_cnt, fail_cnt}, 0);
    check({tag, "_fields"},      {bus.out_x_o, bus.out_y_o, bus.out_z_o, bus.out_col_o,
                                  bus.zb_func_o}, 0);
    check({tag, "_zb_base"},     bus.zb_base_o,     0);
  endtask

  typedef struct {
    logic [1:0] x;
    logic [1:0] y;
    logic [7:0] z;
    z_func_t    f;
    logic       exp_pass;
  } vec_t;

  // One fragment through an idle sequencer: latency, issue fields, outcome, counters.
  task automatic run_vec(input int i, input vec_t v);
    int          s0;
    logic [31:0] base;
    logic        outcome, resolved;
    s0         = start_cnt;
    base       = 32'h1000_0000 + 32'(i);
    resolved   = 1'b0;
    outcome    = 1'b0;
    bus.z_func_i    = v.f;
    bus.zbuf_base_i = base;
    bus.out_ready_i = 1'b1;
    drive_frag(v.x, v.y, v.z, 16'hC000 + 16'(i));
    check($sformatf("v%0d_frag_ready", i), bus.frag_ready_o, 1);
    tick();
    bus.frag_valid_i = 1'b0;
    check($sformatf("v%0d_start_early", i), bus.zb_start_o, 0);
    tick();
    check($sformatf("v%0d_start", i), bus.zb_start_o, 1);
    check($sformatf("v%0d_zb_issue", i), {bus.zb_func_o, bus.zb_base_o, bus.zb_x_o, bus.zb_y_o,
          bus.zb_z_o}, {v.f, base, v.x, v.y, v.z});
    for (int k = 0; k < 30 && !resolved; k++) begin
      tick();
      if (bus.out_valid_o) begin
        resolved = 1'b1;
        outcome  = 1'b1;
        check($sformatf("v%0d_out", i), {bus.out_x_o, bus.out_y_o, bus.out_z_o, bus.out_col_o},
              {v.x, v.y, v.z, 16'hC000 + 16'(i)});
      end else if (fail_cnt != 32'(exp_fail_cnt)) begin
        resolved = 1'b1;
      end
    end
    check($sformatf("v%0d_resolved", i), resolved, 1);
    check($sformatf("v%0d_pass", i), outcome, v.exp_pass);
    if (v.exp_pass) exp_pass_cnt++;
    else            exp_fail_cnt++;
    check($sformatf("v%0d_counts", i), {pass_cnt, fail_cnt}, {32'(exp_pass_cnt), 32'(exp_fail_cnt)});
    if (outcome) tick();
    check($sformatf("v%0d_idle", i), {busy, bus.out_valid_o}, 0);
    check($sformatf("v%0d_one_start", i), start_cnt - s0, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 50 && busy; k++) tick();
    check({tag, "_idle"}, busy, 0);
  endtask

  // ---------------- test ----------------
  vec_t      vecs [15];
  fragment_t exp_q [6];
  int        idx, got, stall_at, outs;
  logic      cleared, saw_start, saw_valid;

  initial begin
    vecs[0]  = '{2'd1, 2'd2, 8'd10,  GL_LESS,     1'b1};
    vecs[1]  = '{2'd1, 2'd2, 8'd20,  GL_LESS,     1'b0};
    vecs[2]  = '{2'd1, 2'd2, 8'd10,  GL_EQUAL,    1'b1};
    vecs[3]  = '{2'd1, 2'd2, 8'd9,   GL_GEQUAL,   1'b0};
    vecs[4]  = '{2'd3, 2'd3, 8'd200, GL_GREATER,  1'b0};
    vecs[5]  = '{2'd3, 2'd3, 8'd200, GL_LEQUAL,   1'b1};
    vecs[6]  = '{2'd0, 2'd0, 8'd5,   GL_NEVER,    1'b0};
    vecs[7]  = '{2'd1, 2'd1, 8'd5,   GL_NEVER,    1'b0};
    vecs[8]  = '{2'd2, 2'd2, 8'd5,   GL_NEVER,    1'b0};
    vecs[9]  = '{2'd3, 2'd0, 8'd5,   GL_NEVER,    1'b0};
    vecs[10] = '{2'd0, 2'd0, 8'd7,   GL_ALWAYS,   1'b1};
    vecs[11] = '{2'd1, 2'd1, 8'd7,   GL_ALWAYS,   1'b1};
    vecs[12] = '{2'd2, 2'd2, 8'd7,   GL_ALWAYS,   1'b1};
    vecs[13] = '{2'd3, 2'd0, 8'd7,   GL_ALWAYS,   1'b1};
    vecs[14] = '{2'd3, 2'd3, 8'd200, GL_NOTEQUAL, 1'b0};

    rst = 1'b1;
    bus.frag_valid_i  = 1'b0;
    bus.frag_x_i      = '0;
    bus.frag_y_i      = '0;
    bus.frag_z_i      = '0;
    bus.frag_col_i    = '0;
    bus.clear_valid_i = 1'b0;
    bus.z_func_i      = GL_LESS;
    bus.zbuf_base_i   = '0;
    bus.out_ready_i   = 1'b0;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Six back-to-back fragments with a stalled consumer: 4 queued + 1 in flight before backpressure.
    for (int i = 0; i < 6; i++)
      exp_q[i] = '{x: 2'(i), y: 2'(i >> 2), z: 8'(30 + i), col: 16'hA000 + 16'(i)};
    bus.out_ready_i = 1'b0;
    bus.z_func_i    = GL_ALWAYS;
    idx = 0; got = 0; stall_at = -1;
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      if (cyc == 20) bus.out_ready_i = 1'b1;
      if (idx < 6) drive_frag(exp_q[idx].x, exp_q[idx].y, exp_q[idx].z, exp_q[idx].col);
      else         bus.frag_valid_i = 1'b0;
      if (idx < 6 && !bus.frag_ready_o && stall_at < 0) stall_at = idx;
      if (bus.frag_valid_i && bus.frag_ready_o) idx++;
      if (bus.out_valid_o) begin
        check($sformatf("s3_out%0d", got), {bus.out_x_o, bus.out_y_o, bus.out_z_o, bus.out_col_o},
              exp_q[got]);
        if (bus.out_ready_i) got++;
      end
      if (cyc == 19) check("s3_valid_held", bus.out_valid_o, 1);
      tick();
    end
    bus.frag_valid_i = 1'b0;
    check("s3_accepted_before_stall", stall_at, 5);
    check("s3_all_pushed", idx, 6);
    check("s3_all_delivered", got, 6);
    exp_pass_cnt += 6;
    wait_idle("s3");
    check("s3_counts", {pass_cnt, fail_cnt}, {32'(exp_pass_cnt), 32'(exp_fail_cnt)});

    // Clear requested with two fragments queued: must wait for both, then flush pulse.
    bus.out_ready_i = 1'b1;
    drive_frag(2'd0, 2'd0, 8'd50, 16'hB000);
    tick();
    drive_frag(2'd1, 2'd0, 8'd51, 16'hB001);
    bus.clear_valid_i = 1'b1;
    check("s4_clear_blocked", bus.clear_ready_o, 0);
    tick();
    bus.frag_valid_i = 1'b0;
    outs = 0; cleared = 1'b0;
    for (int cyc = 0; cyc < 100 && !cleared; cyc++) begin
      if (bus.out_valid_o && bus.out_ready_i) outs++;
      if (bus.clear_ready_o) begin
        cleared = 1'b1;
        check("s4_clear_after_frags", outs, 2);
      end
      tick();
    end
    bus.clear_valid_i = 1'b0;
    check("s4_clear_taken", cleared, 1);
    check("s4_flush_pulse", {bus.zb_start_o, bus.zb_flush_o, bus.frag_ready_o}, 3'b110);
    exp_pass_cnt += 2;
    wait_idle("s4");
    check("s4_flush_released", bus.zb_flush_o, 0);
    check("s4_counts", {pass_cnt, fail_cnt}, {32'(exp_pass_cnt), 32'(exp_fail_cnt)});
    run_vec(100, '{2'd0, 2'd0, 8'd254, GL_LESS, 1'b1});

    // Reset while a fragment is in WAIT with two more queued.
    bus.z_func_i = GL_ALWAYS;
    drive_frag(2'd2, 2'd1, 8'd60, 16'hD000);
    tick();
    drive_frag(2'd2, 2'd2, 8'd61, 16'hD001);
    tick();
    drive_frag(2'd2, 2'd3, 8'd62, 16'hD002);
    check("s5_start", bus.zb_start_o, 1);
    tick();
    bus.frag_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    check_reset("s5");
    rst = 1'b0;
    exp_pass_cnt = 0;
    exp_fail_cnt = 0;
    saw_start = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      saw_start |= bus.zb_start_o;
      saw_valid |= bus.out_valid_o;
    end
    check("s5_no_stale_start", saw_start, 0);
    check("s5_no_stale_out", saw_valid, 0);
    check("s5_counts", {pass_cnt, fail_cnt}, 0);

    check("start_done_overlap", coincide_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
